// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the execute stage: ALU control codes and
// the forwarding-select encoding with its priority helper.
package ex_mem_stage_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_WB  = 2'd1,
      FWD_MEM = 2'd2
   } fwd_sel_e;

   // MEM beats WB; register 0 is hard-wired and never forwarded.
   function automatic fwd_sel_e fwd_select(
      input logic [4:0] src,
      input logic [4:0] mem_rd,
      input logic       mem_regwrite,
      input logic [4:0] wb_rd,
      input logic       wb_regwrite
   );
      if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == src))
         return FWD_MEM;
      else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == src))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Bundle of ID/EX inputs, WB feedback, hazard controls and EX/MEM
// outputs. The master drives the EX side and observes the mem_* side.
interface ex_mem_stage_if #(
   parameter int d_size  = 32,
   parameter int ad_size = 32
);
   logic [d_size-1:0]  alu_in1;
   logic [d_size-1:0]  alu_in2;
   logic [d_size-1:0]  alu_input;
   logic [ad_size-1:0] br_address;
   logic [ad_size-1:0] ex_pc4;
   logic [4:0]         alu_shamt;
   logic [4:0]         alu_rs;
   logic [4:0]         alu_rt;
   logic [4:0]         alu_rd;
   logic [3:0]         alu_op;
   logic               alu_src;
   logic               reg_dst;
   logic               alu_regwrite;
   logic               alu_memtoreg;
   logic               alu_mem_write;
   logic               alu_memread;
   logic               pc_branch;
   logic               wb_regwrite;
   logic [4:0]         wb_rd;
   logic [d_size-1:0]  wb_data;
   logic               hold;
   logic               flush;

   logic [d_size-1:0]  mem_alu_result;
   logic [d_size-1:0]  mem_store_data;
   logic [4:0]         mem_rd;
   logic               mem_regwrite;
   logic               mem_memtoreg;
   logic               mem_mem_write;
   logic               mem_memread;
   logic               mem_branch_taken;
   logic [ad_size-1:0] mem_branch_target;
   logic               mem_zero;

   modport master (
      output alu_in1, alu_in2, alu_input, br_address, ex_pc4,
             alu_shamt, alu_rs, alu_rt, alu_rd, alu_op, alu_src, reg_dst,
             alu_regwrite, alu_memtoreg, alu_mem_write, alu_memread, pc_branch,
             wb_regwrite, wb_rd, wb_data, hold, flush,
      input  mem_alu_result, mem_store_data, mem_rd, mem_regwrite,
             mem_memtoreg, mem_mem_write, mem_memread, mem_branch_taken,
             mem_branch_target, mem_zero
   );

   modport slave (
      input  alu_in1, alu_in2, alu_input, br_address, ex_pc4,
             alu_shamt, alu_rs, alu_rt, alu_rd, alu_op, alu_src, reg_dst,
             alu_regwrite, alu_memtoreg, alu_mem_write, alu_memread, pc_branch,
             wb_regwrite, wb_rd, wb_data, hold, flush,
      output mem_alu_result, mem_store_data, mem_rd, mem_regwrite,
             mem_memtoreg, mem_mem_write, mem_memread, mem_branch_taken,
             mem_branch_target, mem_zero
   );
endinterface

// File: rtl/ex_mem_stage_alu_core.sv
// Combinational ALU: logic ops, wrapping add/sub, signed SLT and
// shifts of operand B by shamt. Unknown codes yield 0.
module alu_core
   import ex_mem_stage_pkg::*;
#(
   parameter int d_size = 32
) (
   input  logic [d_size-1:0] a,
   input  logic [d_size-1:0] b,
   input  logic [4:0]        shamt,
   input  logic [3:0]        alu_op,
   output logic [d_size-1:0] result,
   output logic              zero
);

   logic slt;

   always_comb begin
      slt = ($signed(a) < $signed(b));
      result = '0;
      case (alu_op)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_SLT: result = {{(d_size-1){1'b0}}, slt};
         ALU_NOR: result = ~(a | b);
         ALU_SLL: result = b << shamt;
         ALU_SRL: result = b >> shamt;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, branch resolution and the
// EX/MEM pipeline register (flush beats hold).
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int d_size  = 32,
   parameter int ad_size = 32
) (
   input  logic            clk,
   input  logic            rst,
   ex_mem_stage_if.slave   bus
);

   fwd_sel_e            fwd_a;
   fwd_sel_e            fwd_b;
   logic [d_size-1:0]   opnd_a;
   logic [d_size-1:0]   fwd_rt;
   logic [d_size-1:0]   opnd_b;
   logic [d_size-1:0]   alu_result;
   logic                alu_zero;
   logic [4:0]          dest;
   logic [ad_size-1:0]  target;
   logic                taken;

   // Forwarding reads the registered mem_* values, so a held stage
   // keeps supplying its frozen result.
   assign fwd_a = fwd_select(bus.alu_rs, bus.mem_rd, bus.mem_regwrite,
                             bus.wb_rd, bus.wb_regwrite);
   assign fwd_b = fwd_select(bus.alu_rt, bus.mem_rd, bus.mem_regwrite,
                             bus.wb_rd, bus.wb_regwrite);

   always_comb begin
      opnd_a = bus.alu_in1;
      case (fwd_a)
         FWD_MEM: opnd_a = bus.mem_alu_result;
         FWD_WB:  opnd_a = bus.wb_data;
         default: opnd_a = bus.alu_in1;
      endcase
   end

   always_comb begin
      fwd_rt = bus.alu_input;
      case (fwd_b)
         FWD_MEM: fwd_rt = bus.mem_alu_result;
         FWD_WB:  fwd_rt = bus.wb_data;
         default: fwd_rt = bus.alu_input;
      endcase
   end

   assign opnd_b = bus.alu_src ? d_size'(bus.br_address) : fwd_rt;

   alu_core #(.d_size(d_size)) u_alu (
      .a      (opnd_a),
      .b      (opnd_b),
      .shamt  (bus.alu_shamt),
      .alu_op (bus.alu_op),
      .result (alu_result),
      .zero   (alu_zero)
   );

   assign dest   = bus.reg_dst ? bus.alu_rd : bus.alu_rt;
   assign taken  = bus.pc_branch & alu_zero;
   assign target = bus.ex_pc4 + (bus.br_address << 2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst || bus.flush) begin
         bus.mem_alu_result    <= '0;
         bus.mem_store_data    <= '0;
         bus.mem_rd            <= '0;
         bus.mem_regwrite      <= 1'b0;
         bus.mem_memtoreg      <= 1'b0;
         bus.mem_mem_write     <= 1'b0;
         bus.mem_memread       <= 1'b0;
         bus.mem_branch_taken  <= 1'b0;
         bus.mem_branch_target <= '0;
         bus.mem_zero          <= 1'b0;
      end else if (!bus.hold) begin
         bus.mem_alu_result    <= alu_result;
         bus.mem_store_data    <= fwd_rt;
         bus.mem_rd            <= dest;
         bus.mem_regwrite      <= bus.alu_regwrite;
         bus.mem_memtoreg      <= bus.alu_memtoreg;
         bus.mem_mem_write     <= bus.alu_mem_write;
         bus.mem_memread       <= bus.alu_memread;
         bus.mem_branch_taken  <= taken;
         bus.mem_branch_target <= target;
         bus.mem_zero          <= alu_zero;
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: each step drives one EX instruction,
// clocks it and asserts the registered outputs against hand values.
module tb_ex_mem_stage;
   import ex_mem_stage_pkg::*;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   ex_mem_stage_if #(.d_size(32), .ad_size(32)) bus ();

   ex_mem_stage #(.d_size(32), .ad_size(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // {regwrite, memtoreg, mem_write, memread, branch_taken, zero}
   function automatic logic [31:0] ctrl();
      return {26'd0, bus.mem_regwrite, bus.mem_memtoreg, bus.mem_mem_write,
              bus.mem_memread, bus.mem_branch_taken, bus.mem_zero};
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_res"},  bus.mem_alu_result, 32'd0);
      check({tag, "_st"},   bus.mem_store_data, 32'd0);
      check({tag, "_rd"},   {27'd0, bus.mem_rd}, 32'd0);
      check({tag, "_ctrl"}, ctrl(), 32'd0);
      check({tag, "_tgt"},  bus.mem_branch_target, 32'd0);
   endtask

   task automatic clear_ex();
      bus.alu_in1 = 0; bus.alu_in2 = 0; bus.alu_input = 0;
      bus.br_address = 0; bus.ex_pc4 = 0; bus.alu_shamt = 0;
      bus.alu_rs = 0; bus.alu_rt = 0; bus.alu_rd = 0; bus.alu_op = ALU_AND;
      bus.alu_src = 0; bus.reg_dst = 1; bus.alu_regwrite = 0;
      bus.alu_memtoreg = 0; bus.alu_mem_write = 0; bus.alu_memread = 0;
      bus.pc_branch = 0; bus.wb_regwrite = 0; bus.wb_rd = 0; bus.wb_data = 0;
      bus.hold = 0; bus.flush = 0;
   endtask

   // Register-register instruction; alu_input mirrors alu_in2 (rt value).
   task automatic rr(input logic [3:0] op, input logic [4:0] rs, input logic [31:0] a,
                     input logic [4:0] rt, input logic [31:0] b, input logic [4:0] rd);
      clear_ex();
      bus.alu_op = op; bus.alu_rs = rs; bus.alu_in1 = a;
      bus.alu_rt = rt; bus.alu_in2 = b; bus.alu_input = b;
      bus.alu_rd = rd; bus.alu_regwrite = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b0;
      clear_ex();
      #1;
      rst = 1'b1;
      bus.alu_in1 = $urandom; bus.alu_in2 = $urandom; bus.alu_input = $urandom;
      bus.br_address = $urandom; bus.ex_pc4 = $urandom;
      bus.alu_op = 4'($urandom_range(0, 15)); bus.alu_rd = 5'($urandom_range(1, 31));
      bus.alu_regwrite = 1'b1; bus.alu_mem_write = 1'b1; bus.pc_branch = 1'b1;
      #1;
      check_all_zero("rst_async");
      tick();
      tick();
      check_all_zero("rst_held");
      rst = 1'b0;

      // ADD 5+7 -> r9
      rr(ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 5'd9);
      tick();
      check("add_res", bus.mem_alu_result, 32'd12);
      check("add_rd", {27'd0, bus.mem_rd}, 32'd9);
      check("add_ctrl", ctrl(), 32'b100000);
      check("add_st", bus.mem_store_data, 32'd7);

      // rs=r9 from MEM, WB also hits r9 with 3: MEM wins -> 12+1
      rr(ALU_ADD, 5'd9, 32'd0, 5'd3, 32'd1, 5'd10);
      bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'd3;
      tick();
      check("fwd_mem_prio", bus.mem_alu_result, 32'd13);

      // rs=r9 from WB (3), rt=r10 from MEM (13)
      rr(ALU_ADD, 5'd9, 32'd0, 5'd10, 32'd0, 5'd11);
      bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'd3;
      tick();
      check("fwd_wb_mem", bus.mem_alu_result, 32'd16);
      check("fwd_store", bus.mem_store_data, 32'd13);

      // Write to r0, then read r0 with WB also targeting r0: no forwarding
      rr(ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd5, 5'd0);
      tick();
      check("r0_write", bus.mem_alu_result, 32'd10);
      rr(ALU_ADD, 5'd0, 32'd4, 5'd0, 32'd6, 5'd13);
      bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'd99;
      tick();
      check("r0_nofwd", bus.mem_alu_result, 32'd10);

      // Immediate operand: 100 + (-4); store data still the rt value
      rr(ALU_ADD, 5'd1, 32'd100, 5'd5, 32'd7, 5'd14);
      bus.alu_src = 1'b1; bus.br_address = 32'hFFFF_FFFC; bus.reg_dst = 1'b0;
      tick();
      check("imm_res", bus.mem_alu_result, 32'd96);
      check("imm_st", bus.mem_store_data, 32'd7);
      check("imm_rd_rt", {27'd0, bus.mem_rd}, 32'd5);

      // beq taken
      rr(ALU_SUB, 5'd1, 32'd4, 5'd2, 32'd4, 5'd0);
      bus.alu_regwrite = 1'b0; bus.pc_branch = 1'b1;
      bus.ex_pc4 = 32'h100; bus.br_address = 32'hFFFF_FFFE;
      tick();
      check("beq_ctrl", ctrl(), 32'b000011);
      check("beq_tgt", bus.mem_branch_target, 32'h0000_00F8);

      // beq not taken
      rr(ALU_SUB, 5'd1, 32'd4, 5'd2, 32'd5, 5'd0);
      bus.alu_regwrite = 1'b0; bus.pc_branch = 1'b1;
      bus.ex_pc4 = 32'h200; bus.br_address = 32'h4;
      tick();
      check("bne_ctrl", ctrl(), 32'b000000);
      check("bne_res", bus.mem_alu_result, 32'hFFFF_FFFF);
      check("bne_tgt", bus.mem_branch_target, 32'h210);

      // Hold for three cycles
      rr(ALU_AND, 5'd1, 32'h0000_F0F0, 5'd2, 32'h0000_FF00, 5'd15);
      tick();
      check("and_res", bus.mem_alu_result, 32'h0000_F000);
      rr(ALU_OR, 5'd1, 32'd1, 5'd2, 32'd2, 5'd20);
      bus.alu_mem_write = 1'b1;
      bus.hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_res", bus.mem_alu_result, 32'h0000_F000);
         check("hold_rd", {27'd0, bus.mem_rd}, 32'd15);
         check("hold_ctrl", ctrl(), 32'b100000);
      end
      // Release: forwards the held r15 value
      rr(ALU_OR, 5'd15, 32'd0, 5'd3, 32'd1, 5'd16);
      tick();
      check("hold_fwd", bus.mem_alu_result, 32'h0000_F001);

      // Flush alone
      rr(ALU_ADD, 5'd1, 32'd1, 5'd2, 32'd1, 5'd17);
      bus.alu_mem_write = 1'b1; bus.flush = 1'b1;
      tick();
      check_all_zero("flush");

      // Flush beats hold
      rr(ALU_ADD, 5'd1, 32'd1, 5'd2, 32'd1, 5'd17);
      bus.alu_mem_write = 1'b1;
      tick();
      check("pre_hf_ctrl", ctrl(), 32'b101000);
      bus.hold = 1'b1; bus.flush = 1'b1;
      tick();
      check_all_zero("hold_flush");

      // Shifts, SLT, NOR, unknown code, wrap-around
      rr(ALU_SLL, 5'd1, 32'd0, 5'd2, 32'd1, 5'd18);
      bus.alu_shamt = 5'd31;
      tick();
      check("sll31", bus.mem_alu_result, 32'h8000_0000);
      rr(ALU_SRL, 5'd1, 32'd0, 5'd2, 32'h8000_0000, 5'd19);
      bus.alu_shamt = 5'd4;
      tick();
      check("srl4", bus.mem_alu_result, 32'h0800_0000);
      rr(ALU_SLT, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1, 5'd21);
      tick();
      check("slt_neg", bus.mem_alu_result, 32'd1);
      rr(ALU_SLT, 5'd1, 32'd1, 5'd2, 32'hFFFF_FFFF, 5'd21);
      tick();
      check("slt_pos", bus.mem_alu_result, 32'd0);
      check("slt_zero", {31'd0, bus.mem_zero}, 32'd1);
      rr(ALU_NOR, 5'd1, 32'h0F0F_0000, 5'd2, 32'h0000_00FF, 5'd22);
      tick();
      check("nor", bus.mem_alu_result, 32'hF0F0_FF00);
      rr(4'b0011, 5'd1, 32'd7, 5'd2, 32'd9, 5'd23);
      tick();
      check("bad_op", bus.mem_alu_result, 32'd0);
      rr(ALU_SUB, 5'd1, 32'd0, 5'd2, 32'd1, 5'd24);
      tick();
      check("sub_wrap", bus.mem_alu_result, 32'hFFFF_FFFF);
      rr(ALU_ADD, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd2, 5'd25);
      tick();
      check("add_wrap", bus.mem_alu_result, 32'd1);

      // Load result forwarded from MEM even with memread set
      rr(ALU_ADD, 5'd1, 32'd8, 5'd2, 32'd8, 5'd20);
      bus.alu_memread = 1'b1; bus.alu_memtoreg = 1'b1;
      tick();
      check("ld_ctrl", ctrl(), 32'b110100);
      rr(ALU_ADD, 5'd20, 32'd0, 5'd3, 32'd1, 5'd26);
      tick();
      check("ld_fwd", bus.mem_alu_result, 32'd17);

      // Mid-stream async reset, then first instruction after release
      rr(ALU_ADD, 5'd1, 32'd2, 5'd2, 32'd3, 5'd5);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("rst_mid");
      tick();
      check("rst_mid_held", bus.mem_alu_result, 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_idle", bus.mem_alu_result, 32'd0);
      tick();
      check("post_rst_res", bus.mem_alu_result, 32'd5);
      check("post_rst_rd", {27'd0, bus.mem_rd}, 32'd5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage plus EX/MEM pipeline register of the pipelined core. Consumes the ID/EX register outputs and performs:
- operand forwarding from the MEM and WB stages;
- ALU operation and destination-register selection;
- beq branch resolution.

All results are registered one cycle later toward data memory and the branch/flush logic. Hold and flush inputs support hazard stalls and branch squashes.

## Interface
Parameters:
- d_size, 32, datapath width.
- ad_size, 32, address / sign-extended immediate width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- alu_in1, alu_in2, alu_input  in  d_size  rs value, rt value, store data (rt).
- br_address  in  ad_size  sign-extended immediate.
- ex_pc4  in  ad_size  PC+4 of the instruction in EX.
- alu_shamt, alu_rs, alu_rt, alu_rd  in  5 each  shift amount and register numbers.
- alu_op  in  4  ALU control code.
- alu_src  in  1  1 selects br_address as operand B.
- reg_dst  in  1  1 selects alu_rd as destination, 0 selects alu_rt.
- alu_regwrite, alu_memtoreg, alu_mem_write, alu_memread, pc_branch  in  1 each  control bits.
- wb_regwrite  in  1  WB-stage write enable.
- wb_rd  in  5  WB-stage destination register.
- wb_data  in  d_size  WB-stage write data.
- hold  in  1  freeze the EX/MEM register.
- flush  in  1  load a bubble into the EX/MEM register.
- mem_alu_result, mem_store_data  out  d_size  registered ALU result and forwarded store data.
- mem_rd  out  5  registered destination register.
- mem_regwrite, mem_memtoreg, mem_mem_write, mem_memread  out  1 each  registered control bits.
- mem_branch_taken  out  1  registered branch decision.
- mem_branch_target  out  ad_size  registered branch target.
- mem_zero  out  1  registered ALU zero flag.

## Operation
Forwarding is evaluated independently for rs and rt. Priority is MEM, then WB, then register file:
- MEM hit: mem_regwrite=1, mem_rd≠0, mem_rd==reg. Use mem_alu_result.
- WB hit: wb_regwrite=1, wb_rd≠0, wb_rd==reg. Use wb_data.
- Register 0 is never forwarded.
- Load-use hazards are stalled upstream; this block forwards mem_alu_result even when mem_memread=1.

Operands:
- Operand A = forwarded rs.
- Operand B = br_address if alu_src=1, else forwarded rt.
- Store data = forwarded rt, regardless of alu_src.

ALU codes. Add and sub wrap modulo 2^d_size; no overflow output.
- 0000 AND
- 0001 OR
- 0010 ADD
- 0110 SUB
- 0111 SLT (signed; result 1 or 0)
- 1100 NOR
- 1000 SLL B by alu_shamt
- 1001 SRL B by alu_shamt
- Any other code: result 0.

Derived values:
- zero = (result == 0).
- Destination = reg_dst ? alu_rd : alu_rt.
- branch_taken = pc_branch & zero.
- branch_target = ex_pc4 + (br_address << 2), truncated to ad_size.

## Timing
- Latency 1 cycle: EX inputs at edge N appear on mem_* after edge N.
- Reset: every output is 0 immediately on rst, independent of clk, and held while rst=1.
- flush=1 at an edge: all outputs load 0, which is a bubble with no writes and no branch.
- hold=1 (flush=0): all outputs keep their values. Forwarding still reads the held mem_* values.
- flush=1 has priority over hold=1.
- A branch taken in EX is visible one cycle later on mem_branch_taken. The hazard unit flushes younger stages, including this block's next load, using that signal.
- Simultaneous MEM and WB hits on the same register: MEM wins.
- rst asserted mid-stream discards in-flight state. First valid output after release is one edge after the first post-release instruction.

## Structure
- Shared package holds:
  - ALU code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_SLL, ALU_SRL);
  - the forwarding-select encoding (FWD_RF=0, FWD_WB=1, FWD_MEM=2).
- One sub-module, alu_core: combinational, inputs a, b, shamt, alu_op; outputs result and zero.
- Forwarding selection, operand muxes and the EX/MEM register live in ex_mem_stage.

## Test plan
- Reset: rst=1 with random inputs → all outputs 0 asynchronously; they remain 0 until rst falls.
- ADD: alu_in1=5, alu_in2=7, alu_op=0010, alu_src=0, reg_dst=1, alu_rd=9 → next cycle mem_alu_result=12, mem_rd=9, mem_zero=0.
- Forwarding:
  - Back-to-back: first result 12 to r9, second instruction rs=9 with alu_in1=0 → uses 12.
  - wb_rd=9, wb_data=3 also asserted → MEM value 12 still wins.
  - rd=0 → no forwarding.
- beq taken: alu_in1=alu_in2=4, alu_op=0110, pc_branch=1, ex_pc4=0x100, br_address=0xFFFFFFFE → mem_branch_taken=1, mem_branch_target=0xF8.
- Hold/flush:
  - hold=1 for 3 cycles → outputs frozen.
  - hold=1 and flush=1 together → outputs 0.
- Shifts/SLT:
  - SLL with alu_in2=1, shamt=31 → 0x80000000.
  - SLT with -1 vs 1 → 1.
